// File: rtl/connect4_move_ctrl.sv
// Connect-4 move controller: cursor, column heights, player turn and move handshake to the board stage.
// Optional feature macro CURSOR_WRAP_EN: cursor wraps at the board edges instead of saturating.
module connect4_move_ctrl #(
   parameter int COLS  = 7,
   parameter int ROWS  = 6,
   parameter int COL_W = 3,
   parameter int ROW_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             game_clr,
   input  logic             left_pulse,
   input  logic             right_pulse,
   input  logic             drop_pulse,
   output logic             move_valid,
   input  logic             move_ready,
   output logic [COL_W-1:0] move_col,
   output logic [ROW_W-1:0] move_row,
   output logic             move_player,
   output logic [COL_W-1:0] cursor_col,
   output logic             cur_player,
   output logic             col_full,
   output logic             board_full
);

   localparam int               CNT_W    = $clog2(COLS*ROWS+1);
   localparam logic [COL_W-1:0] CUR_INIT = COL_W'(COLS/2);
   localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS-1);
   localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(ROWS);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COLS*ROWS);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FULL} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [COL_W-1:0] r_cursor;
   logic [COL_W-1:0] w_cursor_next;
   logic             r_player;
   logic [ROW_W-1:0] r_heights [COLS];
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_inc;
   logic [COL_W-1:0] r_move_col;
   logic [ROW_W-1:0] r_move_row;
   logic             r_move_player;
   logic             w_col_full;
   logic             w_drop_ok;
   logic             w_accept;

   assign w_col_full  = (r_heights[r_cursor] == ROW_FULL);
   assign w_drop_ok   = (r_state == S_IDLE) && drop_pulse && !w_col_full;
   assign w_accept    = (r_state == S_ISSUE) && move_ready;
   assign w_count_inc = r_count + 1'b1;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= S_IDLE;
      else if (game_clr)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_drop_ok) w_state_next = S_ISSUE;
         S_ISSUE: if (move_ready) w_state_next = (w_count_inc == CNT_FULL) ? S_FULL : S_IDLE;
         S_FULL:  w_state_next = S_FULL;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      move_valid = 1'b0;
      board_full = 1'b0;
      unique case (r_state)
         S_ISSUE: move_valid = 1'b1;
         S_FULL:  board_full = 1'b1;
         default: ;
      endcase
   end

   // Cursor moves only in IDLE, and an accepted drop freezes it for that cycle.
   always_comb begin
      w_cursor_next = r_cursor;
      if (r_state == S_IDLE && !w_drop_ok) begin
         if (left_pulse && !right_pulse) begin
            if (r_cursor == '0)
`ifdef CURSOR_WRAP_EN
               w_cursor_next = COL_MAX;
`else
               w_cursor_next = '0;
`endif
            else
               w_cursor_next = r_cursor - 1'b1;
         end else if (right_pulse && !left_pulse) begin
            if (r_cursor == COL_MAX)
`ifdef CURSOR_WRAP_EN
               w_cursor_next = '0;
`else
               w_cursor_next = COL_MAX;
`endif
            else
               w_cursor_next = r_cursor + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cursor      <= CUR_INIT;
         r_player      <= 1'b0;
         r_count       <= '0;
         r_move_col    <= '0;
         r_move_row    <= '0;
         r_move_player <= 1'b0;
         for (int i = 0; i < COLS; i++) r_heights[i] <= '0;
      end else if (game_clr) begin
         r_cursor      <= CUR_INIT;
         r_player      <= 1'b0;
         r_count       <= '0;
         r_move_col    <= '0;
         r_move_row    <= '0;
         r_move_player <= 1'b0;
         for (int i = 0; i < COLS; i++) r_heights[i] <= '0;
      end else begin
         r_cursor <= w_cursor_next;
         if (w_drop_ok) begin
            r_move_col    <= r_cursor;
            r_move_row    <= r_heights[r_cursor];
            r_move_player <= r_player;
         end
         if (w_accept) begin
            r_player <= ~r_player;
            r_count  <= w_count_inc;
            if (r_heights[r_move_col] != ROW_FULL)
               r_heights[r_move_col] <= r_heights[r_move_col] + 1'b1;
         end
      end
   end

   assign move_col    = r_move_col;
   assign move_row    = r_move_row;
   assign move_player = r_move_player;
   assign cursor_col  = r_cursor;
   assign cur_player  = r_player;
   assign col_full    = w_col_full;

endmodule

// File: tb/tb_connect4_move_ctrl.sv
// Self-checking bench for connect4_move_ctrl: reference model plus a queue of expected moves.
module tb_connect4_move_ctrl;

   typedef struct {
      logic [2:0] col;
      logic [2:0] row;
      logic       pl;
   } mv_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       game_clr = 1'b0;
   logic       left_pulse = 1'b0;
   logic       right_pulse = 1'b0;
   logic       drop_pulse = 1'b0;
   logic       move_ready = 1'b0;
   logic       move_valid;
   logic [2:0] move_col;
   logic [2:0] move_row;
   logic       move_player;
   logic [2:0] cursor_col;
   logic       cur_player;
   logic       col_full;
   logic       board_full;

   connect4_move_ctrl dut (
      .clk(clk), .rst(rst), .game_clr(game_clr),
      .left_pulse(left_pulse), .right_pulse(right_pulse), .drop_pulse(drop_pulse),
      .move_valid(move_valid), .move_ready(move_ready),
      .move_col(move_col), .move_row(move_row), .move_player(move_player),
      .cursor_col(cursor_col), .cur_player(cur_player),
      .col_full(col_full), .board_full(board_full)
   );

   always #5 clk = ~clk;

   int  total = 0;
   int  bad = 0;
   int  m_cursor, m_player, m_count;
   int  m_heights [7];
   mv_t exp_q [$];
   mv_t mon_e;

`ifdef CURSOR_WRAP_EN
   localparam int WRAP_L = 6, WRAP_R = 0;
`else
   localparam int WRAP_L = 0, WRAP_R = 6;
`endif

   function automatic int step_cursor(int c, logic l, logic r);
      if (l && !r) return (c == 0) ? WRAP_L : c - 1;
      if (r && !l) return (c == 6) ? WRAP_R : c + 1;
      return c;
   endfunction

   task automatic model_reset();
      m_cursor = 3;
      m_player = 0;
      m_count  = 0;
      for (int i = 0; i < 7; i++) m_heights[i] = 0;
      exp_q.delete();
   endtask

   // Scoreboard: every cycle the move is offered its payload must equal the queue head.
   always @(negedge clk) begin
      if (move_valid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_move got col=%0d row=%0d player=%0d, required no move",
                     move_col, move_row, move_player);
         end else begin
            if (move_col !== exp_q[0].col || move_row !== exp_q[0].row || move_player !== exp_q[0].pl) begin
               bad++;
               $display("FAIL move_payload got col=%0d row=%0d player=%0d, required col=%0d row=%0d player=%0d",
                        move_col, move_row, move_player, exp_q[0].col, exp_q[0].row, exp_q[0].pl);
            end
            if (move_ready === 1'b1) begin
               mon_e = exp_q.pop_front();
               m_heights[mon_e.col] = m_heights[mon_e.col] + 1;
               m_player = 1 - m_player;
               m_count++;
               $display("move accepted col=%0d row=%0d player=%0d count=%0d",
                        mon_e.col, mon_e.row, mon_e.pl, m_count);
            end
         end
      end
   end

   task automatic cyc(input logic l, input logic r, input logic d);
      left_pulse  = l;
      right_pulse = r;
      drop_pulse  = d;
      @(posedge clk);
      #1;
      left_pulse  = 1'b0;
      right_pulse = 1'b0;
      drop_pulse  = 1'b0;
   endtask

   task automatic move_cursor(input logic l, input logic r);
      if (m_count < 42) m_cursor = step_cursor(m_cursor, l, r);
      cyc(l, r, 1'b0);
      total++;
      if (cursor_col !== 3'(m_cursor)) begin
         bad++;
         $display("FAIL cursor got=%0d required=%0d", cursor_col, m_cursor);
      end
      $display("cursor l=%0b r=%0b -> %0d", l, r, cursor_col);
   endtask

   task automatic do_drop(input int delay, input logic l);
      logic acc;
      mv_t  mv;
      int   n;
      acc = (m_count < 42) && (m_heights[m_cursor] < 6);
      if (acc) begin
         mv.col = 3'(m_cursor);
         mv.row = 3'(m_heights[m_cursor]);
         mv.pl  = 1'(m_player);
         exp_q.push_back(mv);
      end else if (m_count < 42) begin
         m_cursor = step_cursor(m_cursor, l, 1'b0);
      end
      move_ready = (delay == 0);
      cyc(l, 1'b0, 1'b1);
      total++;
      if (move_valid !== acc) begin
         bad++;
         $display("FAIL valid_after_drop got=%0b required=%0b", move_valid, acc);
      end
      if (acc) begin
         repeat (delay) begin @(posedge clk); #1; end
         move_ready = 1'b1;
         n = 0;
         while (exp_q.size() > 0 && n < 20) begin @(posedge clk); #1; n++; end
         total++;
         if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL handshake_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
         end
         total++;
         if (move_valid !== 1'b0 || cur_player !== 1'(m_player) ||
             col_full !== (m_heights[m_cursor] == 6) || board_full !== (m_count == 42) ||
             cursor_col !== 3'(m_cursor)) begin
            bad++;
            $display("FAIL post_accept got valid=%0b player=%0b col_full=%0b board_full=%0b cursor=%0d, required 0/%0d/%0b/%0b/%0d",
                     move_valid, cur_player, col_full, board_full, cursor_col,
                     m_player, (m_heights[m_cursor] == 6), (m_count == 42), m_cursor);
         end
      end else begin
         repeat (3) begin @(posedge clk); #1; end
         total++;
         if (move_valid !== 1'b0 || cursor_col !== 3'(m_cursor)) begin
            bad++;
            $display("FAIL ignored_drop got valid=%0b cursor=%0d, required 0/%0d", move_valid, cursor_col, m_cursor);
         end
      end
      move_ready = 1'b0;
   endtask

   task automatic do_clear();
      game_clr = 1'b1;
      @(posedge clk);
      #1;
      game_clr = 1'b0;
      model_reset();
      total++;
      if (cursor_col !== 3'd3 || cur_player !== 1'b0 || move_valid !== 1'b0 ||
          board_full !== 1'b0 || col_full !== 1'b0) begin
         bad++;
         $display("FAIL game_clr got cursor=%0d player=%0b valid=%0b board_full=%0b col_full=%0b, required 3/0/0/0/0",
                  cursor_col, cur_player, move_valid, board_full, col_full);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      move_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      total++;
      if (cursor_col !== 3'd3 || cur_player !== 1'b0 || col_full !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got cursor=%0d player=%0b col_full=%0b, required 3/0/0", cursor_col, cur_player, col_full);
      end
      total++;
      if ({move_valid, board_full, move_col, move_row, move_player} !== 9'd0) begin
         bad++;
         $display("FAIL reset_outputs got valid=%0b full=%0b col=%0d row=%0d player=%0b, required all 0",
                  move_valid, board_full, move_col, move_row, move_player);
      end
   endtask

   task automatic test_cursor();
      repeat (4) move_cursor(1'b0, 1'b1);
      while (m_cursor > 3) move_cursor(1'b1, 1'b0);
      while (m_cursor < 3) move_cursor(1'b0, 1'b1);
      repeat (4) move_cursor(1'b1, 1'b0);
      while (m_cursor > 3) move_cursor(1'b1, 1'b0);
      while (m_cursor < 3) move_cursor(1'b0, 1'b1);
   endtask

   task automatic test_stall();
      do_drop(5, 1'b0);
   endtask

   task automatic test_column_fill();
      do_clear();
      while (m_cursor > 0) move_cursor(1'b1, 1'b0);
      repeat (6) do_drop(0, 1'b0);
      total++;
      if (col_full !== 1'b1) begin
         bad++;
         $display("FAIL col_full got=%0b required=1", col_full);
      end
      do_drop(0, 1'b0);
   endtask

   task automatic test_simultaneous();
      do_clear();
      move_cursor(1'b1, 1'b1);
      do_drop(0, 1'b1);
   endtask

   task automatic test_board_full();
      do_clear();
      for (int c = 0; c < 7; c++) begin
         while (m_cursor > c) move_cursor(1'b1, 1'b0);
         while (m_cursor < c) move_cursor(1'b0, 1'b1);
         repeat (6) do_drop(0, 1'b0);
      end
      total++;
      if (board_full !== 1'b1) begin
         bad++;
         $display("FAIL board_full got=%0b required=1", board_full);
      end
      move_cursor(1'b1, 1'b0);
      do_drop(0, 1'b0);
      do_clear();
   endtask

   task automatic test_clear_issue();
      mv_t mv;
      do_clear();
      mv.col = 3'd3; mv.row = 3'd0; mv.pl = 1'b0;
      exp_q.push_back(mv);
      move_ready = 1'b0;
      cyc(1'b0, 1'b0, 1'b1);
      repeat (2) begin @(posedge clk); #1; end
      total++;
      if (move_valid !== 1'b1) begin
         bad++;
         $display("FAIL stall_valid got=%0b required=1", move_valid);
      end
      do_clear();
      do_drop(0, 1'b0);
      // Second offer, aborted by async reset between clock edges.
      mv.col = 3'd3; mv.row = 3'd1; mv.pl = 1'b1;
      exp_q.push_back(mv);
      move_ready = 1'b0;
      cyc(1'b0, 1'b0, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      total++;
      if (move_valid !== 1'b0) begin
         bad++;
         $display("FAIL async_reset_valid got=%0b required=0", move_valid);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (cursor_col !== 3'd3 || cur_player !== 1'b0 || move_valid !== 1'b0) begin
         bad++;
         $display("FAIL after_async_reset got cursor=%0d player=%0b valid=%0b, required 3/0/0", cursor_col, cur_player, move_valid);
      end
      do_drop(0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_cursor();
      test_stall();
      test_column_fill();
      test_simultaneous();
      test_board_full();
      test_clear_issue();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired before completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/connect4_move_ctrl.md
# connect4_move_ctrl

Consumes the single-cycle press pulses from the three button debouncers (left, right, drop) and turns them into legal Connect-4 moves. Tracks cursor column, per-column fill heights, the player to move and the total move count. Issues each accepted move to the board-memory / win-check stage over a valid/ready handshake. Sits between the debouncers and the board store; the display reads its cursor and player outputs directly.

## Interface
- COLS, default 7: number of board columns.
- ROWS, default 6: number of board rows.
- COL_W, default 3: width of column indices, and must satisfy 2**COL_W >= COLS.
- ROW_W, default 3: width of row indices and heights, and must satisfy 2**ROW_W > ROWS.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- game_clr  in  1  synchronous game restart; same effect as reset; highest priority.
- left_pulse  in  1  one-cycle press pulse: move cursor left.
- right_pulse  in  1  one-cycle press pulse: move cursor right.
- drop_pulse  in  1  one-cycle press pulse: drop a disc in the cursor column.
- move_valid  out  1  move offered to the board stage.
- move_ready  in  1  board stage accepts the move.
- move_col  out  COL_W  column of the offered move.
- move_row  out  ROW_W  row of the offered move; row 0 is the bottom.
- move_player  out  1  owner of the offered move: 0 = player A, 1 = player B.
- cursor_col  out  COL_W  current cursor column.
- cur_player  out  1  player to move.
- col_full  out  1  the cursor column holds ROWS discs.
- board_full  out  1  COLS*ROWS moves have been accepted.

## Operation
- States: IDLE, ISSUE, FULL.
- Reset and game_clr put the block in IDLE with:
  - cursor_col = COLS/2 (3 at the defaults);
  - cur_player = 0;
  - all heights and the move count = 0;
  - move_valid = 0, move_col = 0, move_row = 0, move_player = 0, board_full = 0.
- IDLE:
  - drop_pulse with col_full = 0 latches move_col = cursor_col, move_row = heights[cursor_col] and move_player = cur_player, then goes to ISSUE.
  - drop_pulse with col_full = 1 is ignored. The state does not change.
  - drop_pulse takes priority over a left or right pulse in the same cycle; the cursor does not move that cycle.
  - left_pulse alone decrements the cursor; right_pulse alone increments it.
  - left_pulse and right_pulse together cause no cursor change.
  - Edge behaviour without wrap: saturates at 0 and at COLS-1.
- ISSUE:
  - move_valid = 1, and move_col/move_row/move_player are held stable.
  - All pulses are ignored, so the cursor is frozen.
  - When move_valid & move_ready:
    - heights[move_col] increments, cur_player toggles and the move count increments;
    - if the new count equals COLS*ROWS, go to FULL with board_full = 1; otherwise go to IDLE.
- FULL: all pulses are ignored; the block leaves FULL only on game_clr or reset.
- col_full = (heights[cursor_col] == ROWS), decoded combinationally from registered state.
- Arithmetic: heights saturate at ROWS and never exceed it. The move count is wide enough to hold COLS*ROWS.

## Timing
- cursor_col updates on the clock edge after the pulse, a latency of 1 cycle.
- move_valid rises 1 cycle after an accepted drop_pulse.
- Handshake: move_valid stays high, with its payload unchanged, until the cycle in which move_ready is sampled high.
- move_valid falls in the cycle after that acceptance. Back-to-back moves therefore need at least 1 IDLE cycle.
- A move accepted when move_ready is already high completes in 1 cycle of ISSUE.
- heights, cur_player and col_full reflect the accepted move on the edge after acceptance.
- game_clr during ISSUE drops move_valid on the next edge without completing the move. The board stage must also be cleared by game_clr.
- Asynchronous reset asserted mid-handshake forces move_valid = 0 immediately.

## Configuration
- CURSOR_WRAP_EN:
  - Defined: left from column 0 goes to COLS-1, and right from COLS-1 goes to 0.
  - Undefined: the cursor saturates at both edges.
  - All other behaviour is identical.

## Test plan
- Reset, then 4× right_pulse. Required: cursor_col 3→4→5→6→6. With CURSOR_WRAP_EN the 4th pulse gives 0.
- drop_pulse at column 3 with move_ready held low for 5 cycles. Required: move_valid = 1 with col 3, row 0, player 0, payload stable throughout; after ready, heights[3] = 1, cur_player = 1, move_valid = 0 the next cycle.
- 6 drops in column 0 with ready = 1. Required: rows 0–5 issued in order with alternating players; col_full = 1; a 7th drop_pulse produces no move_valid.
- left_pulse and right_pulse in the same cycle: cursor unchanged. drop_pulse and left_pulse in the same cycle: move in the original column, cursor unchanged.
- Fill all 42 cells. Required: board_full = 1 and state FULL; further pulses produce nothing; game_clr returns to cursor 3, player 0, heights 0.
- Assert game_clr while move_valid = 1 and ready = 0. Required: move_valid = 0 next cycle and heights unchanged; repeat with async rst and check move_valid = 0 with no clock edge.
